uart_rx_byte: RTL and testbench

//   Receives 8N1 asynchronous serial data on the board UART RX pin and delivers

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_bit.sv | 25 ++
 rtl/uart_rx_byte.sv | 128 ++++++++++++
 tb/tb_uart_rx_byte.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART byte receiver and the future transmitter.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  // Clocks per bit, rounded to nearest.
  function automatic integer baud_div(input integer clk_hz, input integer baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchronizer for a single asynchronous pin.
module sync_bit #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: mid-bit sampling FSM with a valid/ready byte output,
// framing-error and overrun pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter integer CLK_FREQUENCY = 50_000_000,
  parameter integer BAUD_RATE     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_err,
  output logic       overrun
);

  localparam integer BAUD_DIV = baud_div(CLK_FREQUENCY, BAUD_RATE);
  localparam integer CW       = $clog2(BAUD_DIV);
  localparam integer IW       = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);
  localparam integer ACT_BAUD = CLK_FREQUENCY / BAUD_DIV;
  localparam integer BAUD_ERR = (ACT_BAUD > BAUD_RATE) ? ACT_BAUD - BAUD_RATE
                                                       : BAUD_RATE - ACT_BAUD;

  generate
    if (BAUD_DIV < 4 || BAUD_ERR * 50 > BAUD_RATE) begin : g_bad_baud
      $error("uart_rx_byte: BAUD_DIV %0d too small or rate error above 2%%", BAUD_DIV);
    end
  endgenerate

  logic rxd_s;

  sync_bit #(.RESET_VALUE(1'b1)) u_sync_rxd (
    .clk (clk),
    .rst (rst),
    .d_i (uart_rxd),
    .q_o (rxd_s)
  );

  uart_rx_state_t            state_q;
  logic [CW-1:0]             bit_cnt_q;
  logic [IW-1:0]             idx_q;
  logic [UART_DATA_BITS-1:0] shreg_q;
  logic                      rxd_prev_q;
  logic [7:0]                rx_data_q;
  logic                      rx_valid_q, framing_err_q, overrun_q;
  logic                      tick;

  assign tick = (bit_cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      idx_q         <= '0;
      shreg_q       <= '0;
      rxd_prev_q    <= 1'b1;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
      rxd_prev_q    <= rxd_s;
      // A same-cycle load in STOP overrides this drop (back-to-back handoff).
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Only a fresh 1->0 edge starts a frame, so a held break never retriggers.
          if (rxd_prev_q && !rxd_s) begin
            state_q   <= START;
            bit_cnt_q <= CNT_HALF;
          end
        end
        START: begin
          if (tick) begin
            if (!rxd_s) begin
              state_q   <= DATA;
              idx_q     <= '0;
              bit_cnt_q <= CNT_FULL;
            end else begin
              state_q   <= IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            shreg_q   <= {rxd_s, shreg_q[UART_DATA_BITS-1:1]};
            bit_cnt_q <= CNT_FULL;
            if (idx_q == IDX_LAST) state_q <= STOP;
            else                   idx_q   <= idx_q + 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            if (!rxd_s) begin
              framing_err_q <= 1'b1;
            end else if (!rx_valid_q || rx_ready) begin
              rx_data_q  <= shreg_q;
              rx_valid_q <= 1'b1;
            end else begin
              overrun_q  <= 1'b1;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte at BAUD_DIV=10: latency, overrun, framing,
// glitch, async reset, break and random back-pressure.
module tb_uart_rx_byte;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 5_000_000;
  localparam int DIV    = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, framing_err, overrun;

  always #5 clk = ~clk;

  uart_rx_byte #(.CLK_FREQUENCY(CLK_HZ), .BAUD_RATE(BAUD)) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rxd    (uart_rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  int  cyc = 0, t0 = 0, rise_cyc = 0;
  int  fe_cnt = 0, ovr_cnt = 0, vhi_cnt = 0, stab_viol = 0;
  int  exp_fe = 0, exp_ovr = 0;
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;
  bit  abort = 0, held = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (framing_err) fe_cnt++;
      if (overrun)     ovr_cnt++;
      if (pv && !pr && (!rx_valid || rx_data !== pd)) stab_viol++;
      if (rx_valid && !pv) rise_cyc = cyc;
      if (rx_valid) vhi_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
        else                   chk("rx_data", rx_data, exp_q.pop_front());
      end
      pv = rx_valid; pr = rx_ready; pd = rx_data;
    end
  end

  // Called and returns at posedge+1. In random mode it drives rx_ready and the
  // hold/overrun model; ready stays constant over the stop bit and 3 clks after.
  task automatic send_byte(input logic [7:0] d, input logic stop, input bit rnd);
    logic [9:0] fr;
    logic       r;
    fr = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      if (abort) begin
        uart_rxd = 1'b1;
        return;
      end
      uart_rxd = fr[b];
      if (b == 0) t0 = cyc;
      if (rnd && b == 9) begin
        r = 1'($urandom_range(0, 1));
        rx_ready = r;
        if (held && !r) exp_ovr++;
        else begin
          exp_q.push_back(d);
          held = !r;
        end
      end
      for (int c = 0; c < DIV; c++) begin
        if (rnd && b < 9 && !(b == 0 && c < 3)) begin
          rx_ready = 1'($urandom_range(0, 1));
          if (rx_ready) held = 0;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  int v0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_fe", framing_err, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    idle(5);

    // single byte, ready high
    rx_ready = 1'b1;
    v0 = vhi_cnt;
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 0);
    v0 = v0;
    idle(5);
    chk("t1_latency", rise_cyc - t0, 98);
    chk("t1_vwidth", vhi_cnt - v0, 1);
    chk("t1_flags", fe_cnt + ovr_cnt, 0);
    chk("t1_sb", exp_q.size(), 0);

    // back-to-back with ready low: second byte overruns
    rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    exp_ovr++;
    send_byte(8'h3C, 1'b1, 0);
    send_byte(8'hC3, 1'b1, 0);
    idle(3);
    chk("t2_hold_data", rx_data, 8'h3C);
    chk("t2_hold_valid", rx_valid, 1);
    chk("t2_ovr", ovr_cnt, exp_ovr);
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    @(posedge clk); #1;
    chk("t2_drop", rx_valid, 0);
    chk("t2_sb", exp_q.size(), 0);

    // framing error, then recovery
    rx_ready = 1'b1;
    exp_fe++;
    send_byte(8'h55, 1'b0, 0);
    idle(DIV);
    chk("t3_fe", fe_cnt, exp_fe);
    exp_q.push_back(8'h01);
    send_byte(8'h01, 1'b1, 0);
    idle(5);
    chk("t3_sb", exp_q.size(), 0);

    // short glitch on idle line
    v0 = vhi_cnt;
    uart_rxd = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    idle(20);
    chk("t4_quiet", vhi_cnt - v0, 0);
    chk("t4_flags", fe_cnt + ovr_cnt, exp_fe + exp_ovr);
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b1, 0);
    idle(5);
    chk("t4_sb", exp_q.size(), 0);

    // async reset mid-frame while a byte is held
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_byte(8'h11, 1'b1, 0);
    idle(3);
    chk("t5_held", rx_data, 8'h11);
    fork
      send_byte(8'h81, 1'b1, 0);
      begin
        repeat (55) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_async_valid", rx_valid, 0);
        chk("t5_async_data", rx_data, 0);
        abort = 1;
        uart_rxd = 1'b1;
        exp_q.delete();
      end
    join
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    abort = 0;
    idle(3 * DIV);
    rx_ready = 1'b1;
    chk("t5_after_rst", rx_valid, 0);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1, 0);
    idle(5);
    chk("t5_sb", exp_q.size(), 0);
    chk("t5_flags", fe_cnt + ovr_cnt, exp_fe + exp_ovr);

    // break: one framing error, no retrigger
    v0 = vhi_cnt;
    exp_fe++;
    uart_rxd = 1'b0;
    repeat (20 * DIV) begin
      @(posedge clk); #1;
    end
    chk("t6_break_fe", fe_cnt, exp_fe);
    idle(3 * DIV);
    chk("t6_break_quiet", vhi_cnt - v0, 0);

    // random back-pressure
    held = 0;
    rx_ready = 1'b0;
    for (int i = 0; i < 256; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 1);
    rx_ready = 1'b1;
    idle(20);
    chk("t6_sb", exp_q.size(), 0);
    chk("t6_ovr", ovr_cnt, exp_ovr);
    chk("t6_fe", fe_cnt, exp_fe);
    chk("stability", stab_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(10 * 100_000);
    $display("FAIL watchdog cycles=%0d limit=%0d", cyc, 100_000);
    $fatal(1, "timeout");
  end

endmodule
